instr_fetch: RTL and testbench

//  Fetch sequencer directly downstream of the program RAM (pram). Drives the pram read address, captures
//  the 3-byte window {byte0,byte1,byte2} on each cmd_start pulse, decodes instruction length, advances the PC
//  and presents one instruction at a time to execute over a valid/ready handshake. Also handles branch

---
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch sequencer between the program RAM and execute. Drives the pram
// address, captures the 3-byte window on each cmd_start pulse, decodes the
// instruction length and hands one instruction at a time to execute.
module instr_fetch #(
  parameter int                  ADDR_W   = 9,
  parameter int                  DATA_W   = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter logic [DATA_W-1:0]   HALT_OP  = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc_addr,
  input  logic [DATA_W-1:0] byte0,
  input  logic [DATA_W-1:0] byte1,
  input  logic [DATA_W-1:0] byte2,
  input  logic              cmd_start,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              stale_q, stale_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] op_q, op_d, opa_q, opa_d, opb_q, opb_d;
  logic [1:0]        len_q, len_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              vld_q, vld_d;
  logic              halt_q, halt_d;

  // Length of the instruction whose opcode is on byte0 right now.
  logic [1:0] dec_len;
  always_comb begin
    dec_len = 2'd3;
    if (byte0 == HALT_OP)                     dec_len = 2'd1;
    else if (byte0[DATA_W-1 -: 2] == 2'b00)   dec_len = 2'd1;
    else if (byte0[DATA_W-1 -: 2] == 2'b01)   dec_len = 2'd2;
  end

  // Next-state: redirect beats everything; a capture advances the PC in step
  // with the pram pulse so it never needs a discard, any other PC change does.
  always_comb begin
    state_d = state_q;
    stale_d = stale_q;
    pc_d    = pc_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    len_d   = len_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    halt_d  = halt_q;
    if (state_q != S_HALTED && redirect_valid) begin
      pc_d    = redirect_addr;
      vld_d   = 1'b0;
      stale_d = 1'b1;
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (cmd_start) begin
            if (stale_q) begin
              stale_d = 1'b0;
            end else if (byte0 == HALT_OP) begin
              halt_d  = 1'b1;
              state_d = S_HALTED;
            end else begin
              op_d    = byte0;
              opa_d   = (dec_len >= 2'd2) ? byte1 : '0;
              opb_d   = (dec_len == 2'd3) ? byte2 : '0;
              len_d   = dec_len;
              ipc_d   = pc_q;
              pc_d    = pc_q + {{(ADDR_W-2){1'b0}}, dec_len};
              vld_d   = 1'b1;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (vld_q && instr_ready) begin
            vld_d   = 1'b0;
            state_d = S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      stale_q <= 1'b1;
      pc_q    <= RESET_PC;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      len_q   <= '0;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      len_q   <= len_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      halt_q  <= halt_d;
    end
  end

  assign pc_addr     = pc_q;
  assign opcode      = op_q;
  assign operand_a   = opa_q;
  assign operand_b   = opb_q;
  assign instr_len   = len_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = vld_q;
  assign halted      = halt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a pram model with a 3-cycle address-to-pulse lag
// feeds the block; an instruction-stream reference (expected PC walked over a
// byte array) checks every accepted instruction.
module tb_instr_fetch;
  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] pc_addr;
  logic [7:0] byte0, byte1, byte2;
  logic       cmd_start;
  logic       instr_valid, instr_ready;
  logic [7:0] opcode, operand_a, operand_b;
  logic [1:0] instr_len;
  logic [8:0] instr_pc;
  logic       redirect_valid;
  logic [8:0] redirect_addr;
  logic       halted;

  instr_fetch dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr),
    .byte0(byte0), .byte1(byte1), .byte2(byte2), .cmd_start(cmd_start),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .instr_len(instr_len), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [512];
  int         nvec = 0;
  int         nerr = 0;
  int         ref_pc = 0;
  int         n_instr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_len(input int op);
    if (op < 64)       return 1;
    else if (op < 128) return 2;
    else               return 3;
  endfunction

  // pram model: samples pc_addr, presents the bytes at that address on a
  // one-cycle pulse three edges later, period 4.
  initial begin : pram
    logic [8:0] a;
    cmd_start = 1'b0;
    byte0 = '0; byte1 = '0; byte2 = '0;
    forever begin
      @(negedge clk);
      cmd_start = 1'b0;
      a = pc_addr;
      repeat (3) @(negedge clk);
      cmd_start = 1'b1;
      byte0 = mem[a];
      byte1 = mem[(int'(a) + 1) % 512];
      byte2 = mem[(int'(a) + 2) % 512];
    end
  end

  // One clock: drive inputs at the negedge and check any handshake that the
  // coming edge will complete against the reference stream.
  task automatic cyc(input bit rdy, input bit redir, input int tgt);
    int l;
    @(negedge clk);
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_addr  = 9'(tgt);
    if (instr_valid && rdy && !redir) begin
      l = ref_len(mem[ref_pc]);
      chk("opcode",    opcode,    mem[ref_pc]);
      chk("operand_a", operand_a, (l >= 2) ? mem[(ref_pc + 1) % 512] : 8'h00);
      chk("operand_b", operand_b, (l == 3) ? mem[(ref_pc + 2) % 512] : 8'h00);
      chk("instr_len", instr_len, l);
      chk("instr_pc",  instr_pc,  ref_pc);
      chk("pc_addr",   pc_addr,   (ref_pc + l) % 512);
      ref_pc = (ref_pc + l) % 512;
      n_instr++;
    end
    if (redir && !halted) ref_pc = tgt;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 60) begin cyc(0, 0, 0); n++; end
    chk("wait_valid", instr_valid, 1);
  endtask

  initial begin
    logic [7:0] s_op;
    logic [8:0] s_pc, s_ipc;
    int n;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 254));
    mem[0] = 8'h01; mem[1] = 8'hAA; mem[2] = 8'hBB;
    mem[4] = 8'h85; mem[5] = 8'h12; mem[6] = 8'h34;
    mem[7] = 8'h45; mem[8] = 8'h56;
    rst = 1'b0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_pc",    pc_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halt",  halted, 0);
    chk("rst_len",   instr_len, 0);
    chk("rst_op",    opcode, 0);
    rst = 1'b1;

    // Back-to-back accepted stream from reset, then random ready/redirect.
    repeat (80) cyc(1, 0, 0);
    chk("stream_progress", (n_instr >= 8) ? 1 : 0, 1);
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, $urandom_range(0, 511));

    // Ready held low across several pulses: instruction and PC frozen.
    wait_valid();
    s_op = opcode; s_pc = pc_addr; s_ipc = instr_pc;
    repeat (20) cyc(0, 0, 0);
    chk("hold_valid", instr_valid, 1);
    chk("hold_op",    opcode, s_op);
    chk("hold_pc",    pc_addr, s_pc);
    chk("hold_ipc",   instr_pc, s_ipc);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("drop_valid", instr_valid, 0);

    // Redirect in HOLD with ready high: pending instruction is dropped.
    wait_valid();
    n = n_instr;
    cyc(1, 1, 'h100);
    cyc(0, 0, 0);
    chk("redir_valid", instr_valid, 0);
    chk("redir_pc",    pc_addr, 'h100);
    chk("redir_nohs",  n_instr, n);
    wait_valid();
    chk("redir_ipc",   instr_pc, 'h100);
    cyc(1, 0, 0);

    // PC wraps past the top of the address space.
    mem[511] = 8'h01;
    cyc(0, 1, 511);
    wait_valid();
    chk("wrap_ipc", instr_pc, 511);
    chk("wrap_pc",  pc_addr, 0);
    cyc(1, 0, 0);

    // HALT: fetching stops, PC frozen, redirects ignored.
    mem['h20] = 8'hFF;
    cyc(1, 1, 'h20);
    n = 0;
    while (!halted && n < 60) begin cyc(1, 0, 0); n++; end
    chk("halted",     halted, 1);
    chk("halt_valid", instr_valid, 0);
    chk("halt_pc",    pc_addr, 'h20);
    for (int i = 0; i < 44; i++) cyc(1, i == 10, 'h55);
    chk("halt_stay",   halted, 1);
    chk("halt_pc2",    pc_addr, 'h20);
    chk("halt_valid2", instr_valid, 0);

    // Reset out of HALTED, then async reset in the middle of HOLD.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    ref_pc = 0;
    wait_valid();
    chk("post_rst_ipc", instr_pc, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_pc",    pc_addr, 0);
    chk("arst_op",    opcode, 0);
    chk("arst_len",   instr_len, 0);
    chk("arst_halt",  halted, 0);
    @(negedge clk); rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
